// File: rtl/fread_chunk_loader.sv
// rtl/fread_chunk_loader.sv - chunked fread-to-RAM loader; watchdog enabled by FREAD_CHUNK_LOADER_TIMEOUT_EN
module fread_chunk_loader #(
    parameter logic [31:0] FILE_ID     = 32'hDABBAD00,
    parameter logic [31:0] FILE_OFFSET = 32'd0,
    parameter int          TOTAL_LEN   = 4096,
    parameter int          CHUNK_LEN   = 2048,
    parameter int          DATA_WIDTH  = 16,
    parameter int          ADDR_WIDTH  = 14,
    parameter logic [23:0] TIMEOUT     = 24'd3000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           req_file_id,
    output logic [31:0]           req_offset,
    output logic [10:0]           req_len,
    output logic                  req_valid,
    input  logic                  req_ready,
    input  logic [7:0]            resp_data,
    input  logic                  resp_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RECV  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int          BPW      = DATA_WIDTH / 8;
    localparam logic [1:0]  LAST_IDX = 2'(BPW - 1);
    localparam logic [20:0] TOTAL21  = 21'(TOTAL_LEN);
    localparam logic [20:0] CHUNK21  = 21'(CHUNK_LEN);

    logic [2:0]            state;
    logic [20:0]           remaining;
    logic [11:0]           chunk_cnt;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-1:0] pack_buf;

    logic                  start_ok;
    logic                  in_xfer;
    logic                  accept;
    logic                  word_full;
    logic                  timeout_hit;
    logic [11:0]           cnt_cur;
    logic [11:0]           cnt_next;
    logic [20:0]           rem_next;
    logic [DATA_WIDTH-1:0] pack_next;

    function automatic logic [10:0] chunk_len_m1(input logic [20:0] rem);
        logic [20:0] n;
        n = (rem > CHUNK21) ? CHUNK21 : rem;
        return 11'(n - 21'd1);
    endfunction

    assign req_file_id = FILE_ID;
    assign start_ok    = start && (state == S_IDLE || state == S_DONE);

    // The handshake cycle itself may carry the first byte of the chunk.
    assign in_xfer   = (state == S_RECV) || (state == S_REQ && req_ready);
    assign accept    = in_xfer && resp_valid;
    assign cnt_cur   = (state == S_REQ) ? ({1'b0, req_len} + 12'd1) : chunk_cnt;
    assign cnt_next  = cnt_cur - {11'd0, accept};
    assign rem_next  = remaining - {20'd0, accept};
    assign word_full = accept && (byte_idx == LAST_IDX);

    always_comb begin
        pack_next = pack_buf;
        for (int k = 0; k < BPW; k++) begin
            if (byte_idx == 2'(k)) pack_next[8*k +: 8] = resp_data;
        end
    end

`ifdef FREAD_CHUNK_LOADER_TIMEOUT_EN
    logic [23:0] wd_cnt;

    assign timeout_hit = (state == S_REQ || state == S_RECV) && !accept
                         && (wd_cnt == TIMEOUT - 24'd1);

    // Every chunk boundary coincides with an accepted byte, so reloading on
    // accept also covers re-entry to REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (start_ok || accept) begin
            wd_cnt <= '0;
        end else if (state == S_REQ || state == S_RECV) begin
            wd_cnt <= wd_cnt + 24'd1;
        end
    end
`else
    // TIMEOUT is only consulted by the watchdog build.
    assign timeout_hit = 1'b0 & (TIMEOUT == 24'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            req_valid  <= 1'b0;
            req_offset <= FILE_OFFSET;
            req_len    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            remaining  <= '0;
            chunk_cnt  <= '0;
            byte_idx   <= '0;
            pack_buf   <= '0;
        end else begin
            wr_en <= 1'b0;
            if (wr_en) wr_addr <= wr_addr + ADDR_WIDTH'(1);

            // Packer runs across chunk boundaries; only start or FLUSH clears it.
            if (accept) begin
                if (word_full) begin
                    wr_en    <= 1'b1;
                    wr_data  <= pack_next;
                    pack_buf <= '0;
                    byte_idx <= '0;
                end else begin
                    pack_buf <= pack_next;
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_REQ;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        req_valid  <= 1'b1;
                        req_offset <= FILE_OFFSET;
                        req_len    <= chunk_len_m1(TOTAL21);
                        remaining  <= TOTAL21;
                        wr_addr    <= '0;
                        byte_idx   <= '0;
                        pack_buf   <= '0;
                    end
                end
                S_REQ, S_RECV: begin
                    if (timeout_hit) begin
                        state     <= S_DONE;
                        req_valid <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                    end else if (in_xfer) begin
                        remaining <= rem_next;
                        chunk_cnt <= cnt_next;
                        if (cnt_next == 12'd0) begin
                            if (rem_next != 21'd0) begin
                                state      <= S_REQ;
                                req_valid  <= 1'b1;
                                req_offset <= req_offset + {21'd0, req_len} + 32'd1;
                                req_len    <= chunk_len_m1(rem_next);
                            end else begin
                                state     <= S_FLUSH;
                                req_valid <= 1'b0;
                            end
                        end else begin
                            state     <= S_RECV;
                            req_valid <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (byte_idx != 2'd0) begin
                        wr_en    <= 1'b1;
                        wr_data  <= pack_buf;
                        pack_buf <= '0;
                        byte_idx <= '0;
                    end else begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fread_chunk_loader.sv
// tb/tb_fread_chunk_loader.sv - randomized self-checking bench for fread_chunk_loader
module tb_fread_chunk_loader;
    localparam logic [31:0] P_ID      = 32'hDABBAD00;
    localparam logic [31:0] P_OFFSET  = 32'hFFFF_FFF0;
    localparam int          P_TOTAL   = 45;
    localparam int          P_CHUNK   = 8;
    localparam int          DW        = 16;
    localparam int          AW        = 4;
    localparam int          BPW       = DW / 8;
    localparam logic [23:0] P_TIMEOUT = 24'd100;

    logic          clk = 1'b0;
    logic          rst, start, req_ready, resp_valid;
    logic [7:0]    resp_data;
    logic          busy, done, error, req_valid, wr_en;
    logic [31:0]   req_file_id, req_offset;
    logic [10:0]   req_len;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]    bytes_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    always #5 clk = ~clk;

    fread_chunk_loader #(
        .FILE_ID(P_ID), .FILE_OFFSET(P_OFFSET), .TOTAL_LEN(P_TOTAL), .CHUNK_LEN(P_CHUNK),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(P_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .req_file_id(req_file_id), .req_offset(req_offset), .req_len(req_len),
        .req_valid(req_valid), .req_ready(req_ready), .resp_data(resp_data),
        .resp_valid(resp_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_load(input bit b2b, input bit mid_start);
        int rem, k, n, j0, waitc, lat, nw;
        logic [31:0] exp_off;
        bytes_q.delete(); wa_q.delete(); wd_q.delete();
        start = 1'b1; step(); start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("done_cleared", 64'(done), 64'(0));
        rem = P_TOTAL;
        k = 0;
        while (rem > 0) begin
            n = (rem < P_CHUNK) ? rem : P_CHUNK;
            exp_off = P_OFFSET + 32'(k * P_CHUNK);
            waitc = 0;
            while (!req_valid && waitc < 20) begin
                resp_valid = b2b; resp_data = 8'($urandom); step(); waitc++;
            end
            chk("req_valid_seen", 64'(req_valid), 64'(1));
            if (!req_valid) begin
                resp_valid = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                chk("req_offset_hold", 64'(req_offset), 64'(exp_off));
                chk("req_len_hold", 64'(req_len), 64'(n - 1));
                resp_valid = b2b; resp_data = 8'($urandom); step();
            end
            chk("req_offset", 64'(req_offset), 64'(exp_off));
            chk("req_len", 64'(req_len), 64'(n - 1));
            chk("req_file_id", 64'(req_file_id), 64'(P_ID));
            req_ready = 1'b1;
            j0 = 0;
            if (b2b) begin
                resp_valid = 1'b1; resp_data = 8'($urandom); bytes_q.push_back(resp_data); j0 = 1;
            end else begin
                resp_valid = 1'b0;
            end
            step(); req_ready = 1'b0;
            if (!(b2b && n == 1 && rem > 1)) chk("req_valid_drop", 64'(req_valid), 64'(0));
            for (int j = j0; j < n; j++) begin
                if (!b2b) begin
                    repeat ($urandom_range(0, 2)) begin
                        resp_valid = 1'b0; resp_data = 8'($urandom); step();
                    end
                end
                resp_valid = 1'b1; resp_data = 8'($urandom); bytes_q.push_back(resp_data);
                start = mid_start && k == 1 && j == 2;
                step(); start = 1'b0;
            end
            rem -= n;
            k++;
        end
        resp_valid = b2b; resp_data = 8'($urandom);
        lat = 1;
        while (!done && lat < 8) begin
            step(); lat++;
        end
        resp_valid = 1'b0;
        chk("done_latency", 64'(lat), 64'((P_TOTAL % BPW != 0) ? 3 : 2));
        chk("done_level", 64'(done), 64'(1));
        chk("busy_end", 64'(busy), 64'(0));
        chk("error_end", 64'(error), 64'(0));
        chk("req_valid_end", 64'(req_valid), 64'(0));
        nw = (P_TOTAL + BPW - 1) / BPW;
        chk("write_count", 64'(wa_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            logic [DW-1:0] ew;
            ew = '0;
            for (int b = 0; b < BPW; b++) begin
                if (i * BPW + b < P_TOTAL) ew = ew | (DW'(bytes_q[i * BPW + b]) << (8 * b));
            end
            chk("wr_addr", 64'(wa_q[i]), 64'(i % (1 << AW)));
            chk("wr_data", 64'(wd_q[i]), 64'(ew));
        end
        chk("wr_addr_final", 64'(wr_addr), 64'(nw % (1 << AW)));
    endtask

    task automatic abort_load();
        start = 1'b1; step(); start = 1'b0;
        req_ready = 1'b1; resp_valid = 1'b0; step(); req_ready = 1'b0;
        repeat (3) begin
            resp_valid = 1'b1; resp_data = 8'($urandom); step();
        end
        rst = 1'b1; step(); rst = 1'b0; resp_valid = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_req_offset", 64'(req_offset), 64'(P_OFFSET));
        wa_q.delete(); wd_q.delete();
        repeat (6) begin
            resp_valid = 1'b1; resp_data = 8'($urandom); step();
        end
        resp_valid = 1'b0; step();
        chk("idle_stray_writes", 64'(wa_q.size()), 64'(0));
        chk("idle_req_valid", 64'(req_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        repeat (3) step();
        chk("rst_busy0", 64'(busy), 64'(0));
        chk("rst_done0", 64'(done), 64'(0));
        chk("rst_error0", 64'(error), 64'(0));
        chk("rst_req_valid0", 64'(req_valid), 64'(0));
        chk("rst_req_offset0", 64'(req_offset), 64'(P_OFFSET));
        chk("rst_req_len0", 64'(req_len), 64'(0));
        chk("rst_wr_en0", 64'(wr_en), 64'(0));
        chk("rst_wr_addr0", 64'(wr_addr), 64'(0));
        chk("rst_wr_data0", 64'(wr_data), 64'(0));
        rst = 1'b0; step();

        run_load(1'b0, 1'b0);
        run_load(1'b1, 1'b1);
        abort_load();
        run_load(1'b0, 1'b1);
        run_load(1'b1, 1'b0);

`ifdef FREAD_CHUNK_LOADER_TIMEOUT_EN
        start = 1'b1; step(); start = 1'b0;
        repeat (99) step();
        chk("to_not_yet", 64'(error), 64'(0));
        step();
        chk("to_error", 64'(error), 64'(1));
        chk("to_busy", 64'(busy), 64'(0));
        chk("to_done", 64'(done), 64'(0));
        chk("to_req_valid", 64'(req_valid), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
